// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide scheduler.
//   - md_op_e    : operation codes driven by EX
//   - md_state_e : scheduler FSM states
//   - md_result_t: {hold, hi, lo} payload produced by md_calc
package md_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // hold=1 means the result must not be written to HI/LO (divide by zero)
  typedef struct packed {
    logic              hold;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

  // True for the ops that occupy the unit for several cycles
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide datapath.
//   op  : operation code (md_op_e encoding)
//   a,b : rs / rt operands
//   res : {hold, hi, lo}; hi=upper product / remainder, lo=lower product / quotient
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output md_result_t        res
);

  logic signed [2*DATA_W-1:0] a_sx;
  logic signed [2*DATA_W-1:0] b_sx;
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic                       sgn_div;
  logic                       a_neg;
  logic                       b_neg;
  logic        [DATA_W-1:0]   dvd;
  logic        [DATA_W-1:0]   dvs;
  logic        [DATA_W-1:0]   q_mag;
  logic        [DATA_W-1:0]   r_mag;
  logic        [DATA_W-1:0]   quo;
  logic        [DATA_W-1:0]   rem;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps back to 0x80000000
  always_comb begin
    a_sx    = {{DATA_W{a[DATA_W-1]}}, a};
    b_sx    = {{DATA_W{b[DATA_W-1]}}, b};
    prod_s  = a_sx * b_sx;
    prod_u  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    sgn_div = (op == MD_DIV);
    a_neg   = sgn_div & a[DATA_W-1];
    b_neg   = sgn_div & b[DATA_W-1];
    dvd     = a_neg ? (~a + DATA_W'(1)) : a;
    dvs     = b_neg ? (~b + DATA_W'(1)) : b;
    // Divisor of zero is replaced to keep the divider defined; result is held anyway
    if (dvs == '0) dvs = DATA_W'(1);
    q_mag   = dvd / dvs;
    r_mag   = dvd % dvs;
    quo     = (a_neg ^ b_neg) ? (~q_mag + DATA_W'(1)) : q_mag;
    rem     = a_neg ? (~r_mag + DATA_W'(1)) : r_mag;

    res = '0;
    case (op)
      MD_MULT:  {res.hi, res.lo} = prod_s;
      MD_MULTU: {res.hi, res.lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res.hold = (b == '0);
        res.hi   = rem;
        res.lo   = quo;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: sequences the multi-cycle mult/div unit beside EX and owns HI/LO.
//   clk, reset    : clock, async active-low reset
//   start_E, op_E : md operation valid in EX and its code
//   rs_E, rt_E    : forwarded operands
//   flush_E       : EX flush, cancels a start
//   md_use_ID     : md-using instruction sits in ID
//   busy          : operation in progress
//   stall_md      : stall request to ID (combinational)
//   done          : one-cycle pulse when HI/LO commit from mult/div
//   hi, lo        : HI/LO registers
module md_scheduler
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_E,
  input  logic [2:0]        op_E,
  input  logic [DATA_W-1:0] rs_E,
  input  logic [DATA_W-1:0] rt_E,
  input  logic              flush_E,
  input  logic              md_use_ID,
  output logic              busy,
  output logic              stall_md,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_result_t        pend_q, pend_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  md_result_t        calc_res;
  logic              go;

  md_calc u_calc (
    .op  (op_E),
    .a   (rs_E),
    .b   (rt_E),
    .res (calc_res)
  );

  assign go = start_E & ~flush_E & (state_q == IDLE);

  // Next-state, counter, pending result and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          case (md_op_e'(op_E))
            MD_MTHI: hi_d = rs_E;
            MD_MTLO: lo_d = rs_E;
            MD_MULT, MD_MULTU: begin
              pend_d  = calc_res;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_d  = calc_res;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (!pend_q.hold) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  // A starting mult/div blocks ID in the same cycle; MTHI/MTLO never do
  assign stall_md = md_use_ID & (busy | (start_E & ~flush_E & md_is_arith(op_E)));

  // ID hazard logic must keep new operations out while the unit is occupied
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(start_E && !flush_E && busy)
  );

endmodule
